pulse_slot_arbiter: RTL and testbench
=====================================

# pulse_slot_arbiter

Round-robin arbiter and sequencer that shares one timed output pulse among four requesters. Each grant drives a fixed-length active window followed by a fixed recovery gap, then the block re-arbitrates. It sits in front of the pulse/FSM datapath and decides which requester owns the next pulse slot. It also sequences the active and gap phases.

## Interface
Parameters:
- HIGH_CYC, default 3: length of the active window in cycles; legal range 1..15.
- GAP_CYC, default 2: length of the recovery gap in cycles; legal range 0..15 (0 means no gap).

Ports:
- CLK  input  1  system clock; all state updates on the posedge.
- RST  input  1  reset; synchronous, active-high; dominates all other inputs.
- REQ  input  4  per-requester request level; REQ[i] is requester i.
- GNT  output  4  one-hot grant; all zero outside ACTIVE; registered.
- GNT_ID  output  2  index of the current or most recent grantee; registered.
- Y_OUT  output  1  shared pulse; 1 exactly while in ACTIVE; registered.
- DONE  output  1  1 during the last ACTIVE cycle of a slot; registered.
- BUSY  output  1  1 whenever state is not IDLE; registered.

## Operation
- Reset: the clock edge with RST=1 sets the following values, effective from the next cycle and regardless of the current state:
  - state = IDLE, counter = 0, LAST = 3
  - GNT = 0, GNT_ID = 0, Y_OUT = 0, DONE = 0, BUSY = 0
- States: IDLE, ACTIVE, GAP. There is a 4-bit down-counter CNT and a 2-bit pointer LAST (the last grantee).
- IDLE:
  - REQ == 0: remain in IDLE.
  - Otherwise, pick the winner W: search upward from index LAST+1 (mod 4), wrapping, and take the first i with REQ[i]=1.
  - On the same edge: state <= ACTIVE, GNT <= onehot(W), GNT_ID <= W, LAST <= W, Y_OUT <= 1, BUSY <= 1, CNT <= HIGH_CYC-1.
  - DONE <= (HIGH_CYC==1).
- ACTIVE:
  - The slot is non-preemptive: dropping REQ[W] or raising other requests does not shorten or alter it.
  - While CNT != 0: CNT <= CNT-1. DONE <= (CNT==1).
  - When CNT == 0:
    - GAP_CYC > 0: state <= GAP, CNT <= GAP_CYC-1.
    - GAP_CYC == 0: state <= IDLE.
    - In both cases GNT <= 0, Y_OUT <= 0, DONE <= 0.
- GAP:
  - Outputs GNT = 0, Y_OUT = 0, BUSY = 1. REQ is ignored.
  - CNT decrements each cycle; at CNT == 0, state <= IDLE and BUSY <= 0.
- Arithmetic: CNT is 4 bits with no wrap; it is always reloaded before underflow. LAST+1 wraps 3 -> 0.
- GNT_ID holds the last winner through GAP and IDLE until the next grant.

## Timing
- Grant latency: REQ sampled high at edge k while in IDLE gives GNT/Y_OUT high from edge k, i.e. visible in the cycle after sampling.
- Y_OUT is high for exactly HIGH_CYC cycles per slot. It is followed by GAP_CYC cycles low, then at least 1 IDLE cycle.
- Back-to-back slot period is HIGH_CYC + GAP_CYC + 1 cycles (6 at defaults).
- DONE is a single-cycle pulse, coincident with the final Y_OUT=1 cycle.
- GNT is never multi-hot. GNT != 0 if and only if Y_OUT = 1.
- Reset mid-ACTIVE or mid-GAP: outputs are 0 in the next cycle; the next slot after reset starts its search at index 0.
- A REQ pulse shorter than one cycle that is not sampled in IDLE is lost; requesters hold REQ until they see GNT.

## Test plan
- Single request:
  - Stimulus: RST for 2 cycles, then REQ=0001 held.
  - Response (defaults): GNT=0001, Y_OUT=1 for 3 cycles; DONE on the 3rd; 2 GAP cycles with BUSY=1; 1 IDLE cycle; then the next slot, again to requester 0.
- Round-robin fairness:
  - Stimulus: REQ=1111 held.
  - Response: GNT_ID sequence 0,1,2,3,0; slot starts spaced 6 cycles apart.
- Skip and wrap:
  - Stimulus: REQ=1010 held from reset.
  - Response: grants alternate 1,3,1,3; the search wraps 3 -> 0 -> 1 correctly.
- Non-preemption:
  - Stimulus: REQ=0100; drop REQ after the 1st ACTIVE cycle and raise REQ=0001.
  - Response: GNT=0100 stays for 3 cycles; requester 0 is granted only after GAP+IDLE.
- Reset mid-slot:
  - Stimulus: assert RST during the 2nd ACTIVE cycle of a grant to requester 2.
  - Response: next cycle GNT=0, Y_OUT=0, BUSY=0, GNT_ID=0. With REQ=0101 after release, requester 0 wins first.
- Parameter corners:
  - Stimulus: HIGH_CYC=1, GAP_CYC=0, REQ=0011.
  - Response: Y_OUT=1 for 1 cycle with DONE=1 in that cycle; period 2 cycles; grants alternate 0,1.

Source files
------------

// File: rtl/pulse_slot_arbiter_if.sv
// Request/grant bundle between four requesters and the shared pulse-slot arbiter.
// master = requester side, slave = arbiter side.
interface pulse_slot_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       Y_OUT;
    logic       DONE;
    logic       BUSY;

    modport master (output REQ, input GNT, GNT_ID, Y_OUT, DONE, BUSY);
    modport slave  (input REQ, output GNT, GNT_ID, Y_OUT, DONE, BUSY);
endinterface

// File: rtl/pulse_slot_arbiter.sv
// Round-robin owner selection for one shared timed pulse: ACTIVE window of HIGH_CYC
// cycles, then GAP_CYC recovery cycles, then re-arbitration from IDLE.
//
// state  | meaning
// IDLE   | no slot owned; arbitrate whenever any REQ is high
// ACTIVE | pulse high for the granted requester, non-preemptive
// GAP    | pulse low, recovery time, requests ignored
module pulse_slot_arbiter #(
    parameter int unsigned HIGH_CYC = 3,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    pulse_slot_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       y_q, y_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && bus.REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        y_d      = y_q;
        done_d   = done_q;
        busy_d   = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_ACTIVE;
                    gnt_d    = 4'b0001 << win_idx;
                    gnt_id_d = win_idx;
                    last_d   = win_idx;
                    y_d      = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = 4'(HIGH_CYC - 1);
                    done_d   = (HIGH_CYC == 1);
                end
            end
            S_ACTIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d  = cnt_q - 4'd1;
                    done_d = (cnt_q == 4'd1);
                end else begin
                    gnt_d  = 4'd0;
                    y_d    = 1'b0;
                    done_d = 1'b0;
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        cnt_d   = 4'(GAP_CYC - 1);
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 2'd3;
            gnt_q    <= 4'd0;
            gnt_id_q <= 2'd0;
            y_q      <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            y_q      <= y_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.GNT_ID = gnt_id_q;
    assign bus.Y_OUT  = y_q;
    assign bus.DONE   = done_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_pulse_slot_arbiter.sv
// Directed plus randomized bench for pulse_slot_arbiter: default timing instance (a)
// and the HIGH_CYC=1/GAP_CYC=0 corner instance (b) checked against a slot-timeline model.
module tb_pulse_slot_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pulse_slot_arbiter_if ifa ();
    pulse_slot_arbiter_if ifb ();

    pulse_slot_arbiter #(.HIGH_CYC(3), .GAP_CYC(2)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
    pulse_slot_arbiter #(.HIGH_CYC(1), .GAP_CYC(0)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    // Model: t = cycles since slot start (-1 when idle); slot spans HIGH+GAP cycles.
    int m_hi[2]   = '{3, 1};
    int m_gap[2]  = '{2, 0};
    int m_t[2]    = '{-1, -1};
    int m_last[2] = '{3, 3};
    int m_id[2]   = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input logic rst, input logic [3:0] req);
        int c;
        bit found;
        if (rst) begin
            m_t[i] = -1; m_last[i] = 3; m_id[i] = 0;
        end else if (m_t[i] < 0) begin
            found = 0;
            for (int j = 1; j <= 4; j++) begin
                c = (m_last[i] + j) % 4;
                if (!found && req[c]) begin
                    found = 1; m_id[i] = c; m_last[i] = c; m_t[i] = 0;
                end
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] >= m_hi[i] + m_gap[i]) m_t[i] = -1;
        end
    endtask

    task automatic check_inst(input int i, input logic [3:0] gnt, input logic [1:0] gid,
                              input logic y, input logic done, input logic busy);
        logic ey;
        ey = (m_t[i] >= 0) && (m_t[i] < m_hi[i]);
        chk($sformatf("y_out%0d", i), 32'(y), 32'(ey));
        chk($sformatf("gnt%0d", i), 32'(gnt), ey ? (32'd1 << m_id[i]) : 32'd0);
        chk($sformatf("gnt_id%0d", i), 32'(gid), 32'(m_id[i]));
        chk($sformatf("done%0d", i), 32'(done), 32'(m_t[i] == m_hi[i] - 1));
        chk($sformatf("busy%0d", i), 32'(busy), 32'(m_t[i] >= 0));
        chk($sformatf("onehot%0d", i), 32'($countones(gnt) <= 1 && ((gnt != 0) == y)), 32'd1);
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge(0, RST, ifa.REQ);
        model_edge(1, RST, ifb.REQ);
        #1;
        check_inst(0, ifa.GNT, ifa.GNT_ID, ifa.Y_OUT, ifa.DONE, ifa.BUSY);
        check_inst(1, ifb.GNT, ifb.GNT_ID, ifb.Y_OUT, ifb.DONE, ifb.BUSY);
    endtask

    int starts_id[$];
    int starts_cyc[$];
    logic prev_y;
    int exp_ids[5] = '{0, 1, 2, 3, 0};

    initial begin
        ifa.REQ = 4'b0000;
        ifb.REQ = 4'b0000;
        RST = 1'b1;
        cyc(); cyc();

        // single request on a, corner pair on b
        RST = 1'b0; ifa.REQ = 4'b0001; ifb.REQ = 4'b0011;
        repeat (14) cyc();

        // round-robin fairness from a fresh reset
        RST = 1'b1; cyc();
        RST = 1'b0; ifa.REQ = 4'b1111; ifb.REQ = 4'b1111;
        prev_y = 1'b0;
        for (int n = 0; n < 28; n++) begin
            cyc();
            if (ifa.Y_OUT && !prev_y) begin
                starts_id.push_back(int'(ifa.GNT_ID));
                starts_cyc.push_back(n);
            end
            prev_y = ifa.Y_OUT;
        end
        chk("fair_count", 32'(starts_id.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < starts_id.size(); k++) begin
            chk("fair_id", 32'(starts_id[k]), 32'(exp_ids[k]));
            if (k > 0) chk("fair_period", 32'(starts_cyc[k] - starts_cyc[k-1]), 32'd6);
        end

        // skip and wrap
        RST = 1'b1; cyc();
        RST = 1'b0; ifa.REQ = 4'b1010; ifb.REQ = 4'b1010;
        repeat (24) cyc();

        // non-preemption: requester 2 keeps its slot after dropping REQ
        RST = 1'b1; cyc();
        RST = 1'b0; ifa.REQ = 4'b0100; ifb.REQ = 4'b0100;
        cyc();
        ifa.REQ = 4'b0001; ifb.REQ = 4'b0001;
        cyc();
        chk("nopreempt_gnt", 32'(ifa.GNT), 32'h4);
        cyc();
        chk("nopreempt_gnt_last", 32'(ifa.GNT), 32'h4);
        repeat (10) cyc();

        // reset during the second ACTIVE cycle of a grant to requester 2
        RST = 1'b1; cyc();
        RST = 1'b0; ifa.REQ = 4'b0100; ifb.REQ = 4'b0000;
        cyc(); cyc();
        chk("midslot_pre_id", 32'(ifa.GNT_ID), 32'd2);
        RST = 1'b1; cyc();
        chk("midslot_gnt", 32'(ifa.GNT), 32'd0);
        chk("midslot_busy", 32'(ifa.BUSY), 32'd0);
        chk("midslot_id", 32'(ifa.GNT_ID), 32'd0);
        RST = 1'b0; ifa.REQ = 4'b0101; ifb.REQ = 4'b0101;
        cyc();
        chk("midslot_first_win", 32'(ifa.GNT), 32'h1);
        repeat (8) cyc();

        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 49) == 0);
            ifa.REQ = 4'($urandom_range(0, 15));
            ifb.REQ = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
